// File: rtl/seq_divider.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock.
// start/busy/done handshake; results held until the next done.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_dz;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dzo;

  logic [WIDTH:0]   w_sh;
  logic [WIDTH:0]   w_t;
  logic             w_neg;

  // Sign bit of the WIDTH+1 subtractor is the borrow.
  assign w_sh  = {r_rem, r_q[WIDTH-1]};
  assign w_t   = w_sh - {1'b0, r_dvs};
  assign w_neg = w_t[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dzo   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvs <= divisor;
            r_cnt <= '0;
            if (divisor == '0) begin
              r_q     <= '1;
              r_rem   <= dividend;
              r_dz    <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_q     <= dividend;
              r_rem   <= '0;
              r_dz    <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_q   <= {r_q[WIDTH-2:0], ~w_neg};
          r_rem <= w_neg ? w_sh[WIDTH-1:0] : w_t[WIDTH-1:0];
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_quot  <= r_q;
          r_remo  <= r_rem;
          r_dzo   <= r_dz;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dzo;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed handshake cases, exhaustive sweep
// and randomized operations against an arithmetic reference model.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int mq(input int a, input int b);
    return (b == 0) ? ((1 << W) - 1) : (a / b);
  endfunction

  function automatic int mr(input int a, input int b);
    return (b == 0) ? a : (a % b);
  endfunction

  task automatic start_op(input int a, input int b);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_start", 32'(busy), 32'(b != 0));
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic finish_op(input int a, input int b, input int pre);
    int   n   = 0;
    logic bad = 1'b0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      if (busy !== (b != 0)) bad = 1'b1;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("latency", n + pre, (b == 0) ? 1 : W + 1);
    chk("busy_run", 32'(bad), 32'd0);
    chk("busy_done", 32'(busy), 32'd0);
    chk("quot", 32'(quotient), mq(a, b));
    chk("rem", 32'(remainder), mr(a, b));
    chk("dz", 32'(div_by_zero), 32'(b == 0));
    if (b != 0) begin
      chk("ident", int'(quotient) * b + int'(remainder), a);
      chk("rem_lt", 32'(int'(remainder) < b), 32'd1);
    end
  endtask

  task automatic run_div(input int a, input int b);
    start_op(a, b);
    finish_op(a, b, 0);
  endtask

  initial begin
    logic seen;
    int   a;
    int   b;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);

    run_div(13, 4);
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("hold_q", 32'(quotient), 32'd3);
    chk("hold_r", 32'(remainder), 32'd1);
    run_div(15, 15);
    run_div(0, 5);
    run_div(15, 1);

    run_div(7, 0);
    run_div(9, 2);

    start_op(13, 4);
    @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = W'(9);
    divisor  = W'(3);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_ign", 32'(busy), 32'd1);
    finish_op(13, 4, 2);
    run_div(9, 3);

    start_op(14, 3);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q", 32'(quotient), 32'd0);
    chk("abort_r", 32'(remainder), 32'd0);
    chk("abort_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("abort_nodone", 32'(seen), 32'd0);
    run_div(14, 3);

    for (int i = 0; i < (1 << W); i++) begin
      for (int j = 0; j < (1 << W); j++) begin
        run_div(i, j);
      end
    end

    repeat (300) begin
      a = int'($urandom_range(0, (1 << W) - 1));
      b = int'($urandom_range(0, (1 << W) - 1));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      run_div(a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
